// File: rtl/instruction_fields_pipe.sv
// instruction_fields_pipe
//   Small instruction buffer between fetch and decode. Each captured word is
//   stored together with its fall-through address (pc + 4). The head entry is
//   split into its raw fields and a few derived values: the extended
//   immediate, the jump target and the instruction format.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake; inst, pc are the fetched word
//   flush               : discards every buffered entry
//   out_valid/out_ready : downstream handshake for the head entry
//   op..target          : raw fields of the head instruction (0 when empty)
//   imm_ext, jump_addr,
//   pc_next, fmt        : derived values of the head entry (0 when empty)
//   count               : current occupancy
module instruction_fields_pipe #(
  parameter int INST_W   = 32,
  parameter int DEPTH    = 2,
  parameter int OP_W     = 6,  parameter int OP_I     = 26,
  parameter int RS_W     = 5,  parameter int RS_I     = 21,
  parameter int RT_W     = 5,  parameter int RT_I     = 16,
  parameter int RD_W     = 5,  parameter int RD_I     = 11,
  parameter int SHAMT_W  = 5,  parameter int SHAMT_I  = 6,
  parameter int FUNC_W   = 6,  parameter int FUNC_I   = 0,
  parameter int IMM_W    = 16, parameter int IMM_I    = 0,
  parameter int TARGET_W = 26, parameter int TARGET_I = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INST_W-1:0]            inst,
  input  logic [INST_W-1:0]            pc,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OP_W-1:0]              op,
  output logic [RS_W-1:0]              rs,
  output logic [RT_W-1:0]              rt,
  output logic [RD_W-1:0]              rd,
  output logic [SHAMT_W-1:0]           shamt,
  output logic [FUNC_W-1:0]            func,
  output logic [IMM_W-1:0]             imm,
  output logic [TARGET_W-1:0]          target,
  output logic [INST_W-1:0]            imm_ext,
  output logic [INST_W-1:0]            jump_addr,
  output logic [INST_W-1:0]            pc_next,
  output logic [1:0]                   fmt,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] pcn;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = !rst && (count < CNT_W'(DEPTH));
  assign out_valid = !rst && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage carries no reset: an entry is only visible through count, so
  // stale words left behind by flush or reset are never observed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr].inst <= inst;
      mem[wr_ptr].pcn  <= pc + INST_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Head decode; everything reads as zero while the buffer is empty so
  // decode never sees a stale word.
  always_comb begin
    op        = '0;
    rs        = '0;
    rt        = '0;
    rd        = '0;
    shamt     = '0;
    func      = '0;
    imm       = '0;
    target    = '0;
    imm_ext   = '0;
    jump_addr = '0;
    pc_next   = '0;
    fmt       = 2'd0;
    if (out_valid) begin
      op      = head.inst[OP_I     +: OP_W];
      rs      = head.inst[RS_I     +: RS_W];
      rt      = head.inst[RT_I     +: RT_W];
      rd      = head.inst[RD_I     +: RD_W];
      shamt   = head.inst[SHAMT_I  +: SHAMT_W];
      func    = head.inst[FUNC_I   +: FUNC_W];
      imm     = head.inst[IMM_I    +: IMM_W];
      target  = head.inst[TARGET_I +: TARGET_W];
      pc_next = head.pcn;
      // Logical immediates (andi/ori/xori) zero-extend, the rest sign-extend.
      if (op == OP_W'(12) || op == OP_W'(13) || op == OP_W'(14))
        imm_ext = {{(INST_W-IMM_W){1'b0}}, imm};
      else
        imm_ext = {{(INST_W-IMM_W){imm[IMM_W-1]}}, imm};
      // Jump region comes from the delay-slot address, not the jump's own pc.
      jump_addr = {head.pcn[INST_W-1:TARGET_W+2], target, 2'b00};
      if (op == '0)
        fmt = 2'd0;
      else if (op == OP_W'(2) || op == OP_W'(3))
        fmt = 2'd2;
      else
        fmt = 2'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fields_pipe.sv
module tb_instruction_fields_pipe;
  localparam int DEPTH = 2;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst, pc, imm_ext, jump_addr, pc_next;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [1:0]  fmt, count;

  instruction_fields_pipe #(.INST_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .func(func), .imm(imm), .target(target),
    .imm_ext(imm_ext), .jump_addr(jump_addr), .pc_next(pc_next),
    .fmt(fmt), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic [31:0] pcn; } ent_t;
  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  wire [175:0] obs = {out_valid, in_ready, count, op, rs, rt, rd, shamt, func,
                      imm, target, imm_ext, jump_addr, pc_next, fmt};

  // Reference: decode the queue head straight from the instruction-set rules.
  function automatic logic [175:0] model_vec();
    logic [31:0] x, pn, iv, ie, ja;
    int          o;
    logic [1:0]  fm;
    if (rst) return '0;
    if (q.size() == 0) return {1'b0, 1'b1, 174'd0};
    x  = q[0].inst;
    pn = q[0].pcn;
    o  = int'((x >> 26) & 32'h3F);
    iv = x & 32'hFFFF;
    if (o == 12 || o == 13 || o == 14) ie = iv;
    else ie = (iv >= 32'h8000) ? (iv | 32'hFFFF_0000) : iv;
    ja = (pn & 32'hF000_0000) | ((x & 32'h03FF_FFFF) << 2);
    fm = (o == 0) ? 2'd0 : ((o == 2 || o == 3) ? 2'd2 : 2'd1);
    return {1'b1, q.size() < DEPTH, 2'(q.size()), 6'(x >> 26), 5'(x >> 21),
            5'(x >> 16), 5'(x >> 11), 5'(x >> 6), 6'(x), 16'(x), 26'(x),
            ie, ja, pn, fm};
  endfunction

  // One clock with the given inputs; inputs change on the falling edge and
  // the model advances alongside the rising edge.
  task automatic tick(input logic v, input logic [31:0] i, input logic [31:0] p,
                      input logic r, input logic f);
    logic do_push, do_pop;
    in_valid = v; inst = i; pc = p; out_ready = r; flush = f;
    do_push = v && (q.size() < DEPTH);
    do_pop  = r && (q.size() > 0);
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{i, p + 32'd4});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; out_ready = 0; flush = 0; inst = 0; pc = 0;
    @(negedge clk);
    n_cmp++;
    if (obs !== 176'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    rst = 1'b0; q.delete();
    #1;
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++; $display("FAIL reset_release: got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_rtype();
    tick(1, 32'h012A_4020, 32'h0040_0000, 0, 0);
    n_cmp++;
    if ({out_valid, fmt, rs, rt, rd, func, pc_next} !==
        {1'b1, 2'd0, 5'd9, 5'd10, 5'd8, 6'h20, 32'h0040_0004}) begin
      n_bad++; $display("FAIL rtype_add: got v%b f%0d rs%0d rt%0d rd%0d fn%h pcn%h",
                        out_valid, fmt, rs, rt, rd, func, pc_next);
    end
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++; $display("FAIL rtype_all: got %h want %h", obs, model_vec());
    end
    tick(0, 0, 0, 1, 0);
  endtask

  task automatic test_imm();
    tick(1, 32'h2108_FFFF, 32'h0000_1000, 0, 0);
    n_cmp++;
    if (imm_ext !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL addi_sext: got %h want ffffffff", imm_ext);
    end
    tick(1, 32'h3508_FFFF, 32'h0000_1004, 1, 0);
    n_cmp++;
    if (imm_ext !== 32'h0000_FFFF || fmt !== 2'd1) begin
      n_bad++; $display("FAIL ori_zext: got %h fmt %0d want 0000ffff fmt 1", imm_ext, fmt);
    end
    tick(0, 0, 0, 1, 0);
  endtask

  task automatic test_jump();
    tick(1, 32'h0810_0004, 32'h1000_0000, 0, 0);
    n_cmp++;
    if (fmt !== 2'd2 || jump_addr !== 32'h1040_0010) begin
      n_bad++; $display("FAIL jump: got fmt %0d ja %h want 2 10400010", fmt, jump_addr);
    end
    tick(0, 0, 0, 1, 0);
  endtask

  task automatic test_full_hold();
    tick(1, 32'h0123_4567, 32'h0000_2000, 0, 0);
    tick(1, 32'h89AB_CDEF, 32'h0000_2004, 0, 0);
    n_cmp++;
    if (count !== 2'd2 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL full: got count %0d in_ready %b want 2 0", count, in_ready);
    end
    tick(1, 32'hDEAD_BEEF, 32'h0000_2008, 0, 0);
    n_cmp++;
    if (count !== 2'd2 || rd !== 5'd8 || pc_next !== 32'h0000_2004) begin
      n_bad++; $display("FAIL hold_head: got count %0d rd %0d pcn %h want 2 8 00002004",
                        count, rd, pc_next);
    end
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++; $display("FAIL hold_all: got %h want %h", obs, model_vec());
    end
  endtask

  // Starts full; push+pop every cycle walks both pointers past the wrap.
  task automatic test_wrap();
    for (int k = 0; k < 5; k++) begin
      tick(1, $urandom, $urandom & 32'hFFFF_FFFC, 1, 0);
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++; $display("FAIL wrap_%0d: got %h want %h", k, obs, model_vec());
      end
    end
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    n_cmp++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL wrap_drain: got count %0d v %b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_flush_rst();
    tick(1, 32'h2108_0001, 32'h0000_3000, 0, 0);
    tick(1, 32'h2108_0002, 32'h0000_3004, 1, 1);
    n_cmp++;
    if (obs !== {1'b0, 1'b1, 174'd0}) begin
      n_bad++; $display("FAIL flush_push: got %h want empty", obs);
    end
    tick(1, 32'h0000_0001, 32'h0000_3008, 0, 0);
    tick(1, 32'h0000_0002, 32'h0000_300C, 0, 0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 176'd0) begin
      n_bad++; $display("FAIL rst_async: got %h want 0", obs);
    end
    q.delete();
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== 176'd0) begin
      n_bad++; $display("FAIL rst_held: got %h want 0", obs);
    end
    rst = 1'b0;
    tick(1, 32'h3C01_1234, 32'h0000_4000, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b1 || count !== 2'd1 || obs !== model_vec()) begin
      n_bad++; $display("FAIL rst_first_push: got %h want %h", obs, model_vec());
    end
    tick(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    int ops [8] = '{0, 2, 3, 8, 12, 13, 14, 35};
    logic [31:0] w;
    for (int k = 0; k < 300; k++) begin
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w = (w & 32'h03FF_FFFF) | (32'(ops[$urandom_range(7, 0)]) << 26);
      tick($urandom_range(3, 0) != 0, w, $urandom, $urandom_range(1, 0) == 1,
           $urandom_range(19, 0) == 0);
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++; $display("FAIL random_%0d: got %h want %h", k, obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_jump();
    test_full_hold();
    test_wrap();
    test_flush_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
